// File: rtl/mopshub_test_pkg.sv
// Shared types for the MOPSHUB bus test sequencer.
//   seq_state_t : sequencer FSM states
//   test_mode_t : which test kinds run per bus
//   CNT_W       : width of the saturating pass / timeout counters
//   first_state : entry test state for a given mode
package mopshub_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN_RX,
    ST_ENDWAIT,
    ST_GAP,
    ST_RUN_TX,
    ST_RUN_ADV,
    ST_NEXT,
    ST_DONE
  } seq_state_t;

  typedef enum logic [1:0] {
    MODE_RX,
    MODE_TX,
    MODE_RX_TX,
    MODE_ADV
  } test_mode_t;

  // Counters of this width stop at all-ones instead of wrapping.
  localparam int unsigned CNT_W = 16;

  // First test state entered for each bus in the given mode.
  function automatic seq_state_t first_state(input test_mode_t m);
    case (m)
      MODE_TX:  return ST_RUN_TX;
      MODE_ADV: return ST_RUN_ADV;
      default:  return ST_RUN_RX;
    endcase
  endfunction

endpackage

// File: rtl/mopshub_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst : clock, synchronous active-high reset
//   inc      : add one unless already at all-ones
//   clr      : return to zero (wins over inc)
//   q        : registered count
module mopshub_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != {W{1'b1}})) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/mopshub_bus_test_sequencer.sv
// Walks buses 0..n_buses-1 raising one RX / TX / advanced test request at a
// time, waits for the matching end strobe or a timeout, and keeps per-bus
// pass/fail maps plus pass and timeout counters.
//   clk, rst                 : clock, synchronous active-high reset
//   start, abort             : begin a run (from IDLE/DONE) / return to IDLE
//   mode, loop_en, n_buses   : run configuration (mode, n_buses latched at start)
//   test_*_end, test_ok      : end strobes and result from the tb environment
//   test_rx/tx/adv, bus_sel  : registered request levels and bus under test
//   endwait_all              : one-cycle pulse after each completed RX test
//   busy, done               : run in progress / single pass finished
//   pass_map, fail_map       : per-bus results
//   pass_cnt, timeout_cnt    : saturating pass and timeout counters
module mopshub_bus_test_sequencer
  import mopshub_test_pkg::*;
#(
  parameter int unsigned N_BUS       = 16,
  parameter int unsigned BUS_W       = 5,
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter int unsigned GAP_CYC     = 120
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  input  logic             loop_en,
  input  logic [BUS_W-1:0] n_buses,
  input  logic             test_rx_end,
  input  logic             test_tx_end,
  input  logic             test_adv_end,
  input  logic             test_ok,
  output logic             test_rx,
  output logic             test_tx,
  output logic             test_adv,
  output logic [BUS_W-1:0] bus_sel,
  output logic             endwait_all,
  output logic             busy,
  output logic             done,
  output logic [N_BUS-1:0] pass_map,
  output logic [N_BUS-1:0] fail_map,
  output logic [15:0]      pass_cnt,
  output logic [15:0]      timeout_cnt
);

  localparam int unsigned TMAX    = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
  localparam int unsigned TIMER_W = $clog2(TMAX + 1);

  seq_state_t       state_q, state_d;
  test_mode_t       mode_q, mode_d;
  logic [BUS_W-1:0] bus_sel_q, bus_sel_d;
  logic [BUS_W-1:0] eff_n_q, eff_n_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [N_BUS-1:0] pass_map_q, pass_map_d;
  logic [N_BUS-1:0] fail_map_q, fail_map_d;
  logic             test_rx_q, test_rx_d;
  logic             test_tx_q, test_tx_d;
  logic             test_adv_q, test_adv_d;
  logic             endwait_q, endwait_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             pass_inc_c, to_inc_c, cnt_clr_c;
  logic             strobe_c, timeout_c, last_bus_c;
  logic [N_BUS-1:0] bus_mask_c;
  logic [BUS_W-1:0] n_clamp_c;

  // Decode of the current bus, the clamped bus count and the accepted strobe.
  always_comb begin
    bus_mask_c = N_BUS'(1) << bus_sel_q;
    n_clamp_c  = (n_buses > BUS_W'(N_BUS)) ? BUS_W'(N_BUS) : n_buses;
    last_bus_c = (bus_sel_q == (eff_n_q - BUS_W'(1)));
    timeout_c  = (timer_q == TIMER_W'(TIMEOUT_CYC - 1));
    case (state_q)
      ST_RUN_RX:  strobe_c = test_rx_end;
      ST_RUN_TX:  strobe_c = test_tx_end;
      ST_RUN_ADV: strobe_c = test_adv_end;
      default:    strobe_c = 1'b0;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    bus_sel_d  = bus_sel_q;
    eff_n_d    = eff_n_q;
    timer_d    = '0;
    pass_map_d = pass_map_q;
    fail_map_d = fail_map_q;
    pass_inc_c = 1'b0;
    to_inc_c   = 1'b0;
    cnt_clr_c  = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            pass_map_d = '0;
            fail_map_d = '0;
            cnt_clr_c  = 1'b1;
            bus_sel_d  = '0;
            eff_n_d    = n_clamp_c;
            mode_d     = test_mode_t'(mode);
            state_d    = (n_clamp_c == '0) ? ST_DONE : first_state(test_mode_t'(mode));
          end
        end
        ST_RUN_RX, ST_RUN_TX, ST_RUN_ADV: begin
          // A strobe on the timeout cycle still counts as a normal end.
          if (strobe_c || timeout_c) begin
            if (!strobe_c || !test_ok) begin
              fail_map_d = fail_map_q | bus_mask_c;
            end
            to_inc_c = !strobe_c;
            state_d  = (state_q == ST_RUN_RX) ? ST_ENDWAIT : ST_NEXT;
          end else begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end
        ST_ENDWAIT: begin
          state_d = (mode_q == MODE_RX_TX) ? ST_GAP : ST_NEXT;
        end
        ST_GAP: begin
          if (timer_q == TIMER_W'(GAP_CYC - 1)) begin
            state_d = ST_RUN_TX;
          end else begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end
        ST_NEXT: begin
          pass_map_d = (pass_map_q & ~bus_mask_c) | (~fail_map_q & bus_mask_c);
          if (last_bus_c) begin
            pass_inc_c = 1'b1;
            if (loop_en) begin
              // fail_map stays sticky across passes; pass_map is rebuilt.
              bus_sel_d  = '0;
              pass_map_d = '0;
              state_d    = first_state(mode_q);
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            bus_sel_d = bus_sel_q + BUS_W'(1);
            state_d   = first_state(mode_q);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    test_rx_d  = (state_d == ST_RUN_RX);
    test_tx_d  = (state_d == ST_RUN_TX);
    test_adv_d = (state_d == ST_RUN_ADV);
    endwait_d  = (state_d == ST_ENDWAIT);
    done_d     = (state_d == ST_DONE);
    busy_d     = (state_d != ST_IDLE) && (state_d != ST_DONE);
  end

  // FSM, timer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_RX;
      bus_sel_q  <= '0;
      eff_n_q    <= '0;
      timer_q    <= '0;
      pass_map_q <= '0;
      fail_map_q <= '0;
      test_rx_q  <= 1'b0;
      test_tx_q  <= 1'b0;
      test_adv_q <= 1'b0;
      endwait_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      bus_sel_q  <= bus_sel_d;
      eff_n_q    <= eff_n_d;
      timer_q    <= timer_d;
      pass_map_q <= pass_map_d;
      fail_map_q <= fail_map_d;
      test_rx_q  <= test_rx_d;
      test_tx_q  <= test_tx_d;
      test_adv_q <= test_adv_d;
      endwait_q  <= endwait_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  mopshub_sat_counter #(.W(CNT_W)) u_pass_cnt (
    .clk (clk),
    .rst (rst),
    .inc (pass_inc_c),
    .clr (cnt_clr_c),
    .q   (pass_cnt)
  );

  mopshub_sat_counter #(.W(CNT_W)) u_timeout_cnt (
    .clk (clk),
    .rst (rst),
    .inc (to_inc_c),
    .clr (cnt_clr_c),
    .q   (timeout_cnt)
  );

  assign test_rx     = test_rx_q;
  assign test_tx     = test_tx_q;
  assign test_adv    = test_adv_q;
  assign bus_sel     = bus_sel_q;
  assign endwait_all = endwait_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass_map    = pass_map_q;
  assign fail_map    = fail_map_q;

endmodule

// File: tb/tb_mopshub_bus_test_sequencer.sv
// Scoreboard bench: stimulus builds a per-test plan (strobe delay, result),
// a reference model turns it into expected request events and run results,
// a responder plays the tb environment, and a monitor checks what the DUT shows.
module tb_mopshub_bus_test_sequencer;

  localparam int N_BUS       = 16;
  localparam int BUS_W       = 5;
  localparam int TIMEOUT_CYC = 4096;
  localparam int GAP_CYC     = 120;

  logic clk = 1'b0;
  logic rst, start, abort, loop_en;
  logic [1:0] mode;
  logic [BUS_W-1:0] n_buses;
  logic test_rx_end, test_tx_end, test_adv_end, test_ok;
  logic test_rx, test_tx, test_adv, endwait_all, busy, done;
  logic [BUS_W-1:0] bus_sel;
  logic [N_BUS-1:0] pass_map, fail_map;
  logic [15:0] pass_cnt, timeout_cnt;

  always #5 clk = ~clk;

  mopshub_bus_test_sequencer #(
    .N_BUS(N_BUS), .BUS_W(BUS_W), .TIMEOUT_CYC(TIMEOUT_CYC), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
    .loop_en(loop_en), .n_buses(n_buses), .test_rx_end(test_rx_end),
    .test_tx_end(test_tx_end), .test_adv_end(test_adv_end), .test_ok(test_ok),
    .test_rx(test_rx), .test_tx(test_tx), .test_adv(test_adv), .bus_sel(bus_sel),
    .endwait_all(endwait_all), .busy(busy), .done(done), .pass_map(pass_map),
    .fail_map(fail_map), .pass_cnt(pass_cnt), .timeout_cnt(timeout_cnt)
  );

  // d >= 0: strobe d cycles after request rises; -1: never (timeout); -2: cut by abort/rst
  typedef struct { int d; bit ok; } plan_t;
  typedef struct { int kind; int bus; int len; } ev_t;
  typedef struct { logic [N_BUS-1:0] pm; logic [N_BUS-1:0] fm; int pc; int tc; } res_t;

  plan_t plan_q[$];
  plan_t resp_q[$];
  ev_t   ev_q[$];
  res_t  res_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int cur_mode = 0;
  int ew_cnt = 0;
  int exp_ew = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit req_hi(input int k);
    return (k == 0) ? test_rx : (k == 1) ? test_tx : test_adv;
  endfunction

  task automatic clear_ends();
    test_rx_end = 1'b0; test_tx_end = 1'b0; test_adv_end = 1'b0; test_ok = 1'b0;
  endtask

  // Responder: acts as the tb environment, one request at a time.
  initial begin : responder
    plan_t p;
    int k;
    int w;
    clear_ends();
    forever begin
      @(negedge clk);
      if (test_rx | test_tx | test_adv) begin
        k = test_rx ? 0 : (test_tx ? 1 : 2);
        if (resp_q.size() > 0) p = resp_q.pop_front();
        else p = '{d: -2, ok: 1'b1};
        w = 0;
        while (req_hi(k)) begin
          if (p.d >= 0 && w == p.d) begin
            if (k == 0) test_rx_end = 1'b1;
            else if (k == 1) test_tx_end = 1'b1;
            else test_adv_end = 1'b1;
            test_ok = p.ok;
            @(negedge clk);
            break;
          end
          // non-matching strobes with a failing result must be ignored
          if (w == 0 && (p.d < 0 || p.d >= 2)) begin
            test_rx_end = (k != 0); test_tx_end = (k != 1); test_adv_end = (k != 2);
            test_ok = 1'b0;
          end
          @(negedge clk);
          clear_ends();
          w++;
        end
        clear_ends();
        while (test_rx | test_tx | test_adv) @(negedge clk);
      end
    end
  end

  // Monitor: compares observed requests and run results with the scoreboard.
  logic prev_any = 1'b0, prev_done = 1'b0, prev_ew = 1'b0;
  int hi_len = 0, len_exp = -1, ew_cyc = 0;
  always @(negedge clk) begin : monitor
    ev_t e;
    res_t r;
    int k;
    logic any_now;
    if (mon_en) begin
      any_now = test_rx | test_tx | test_adv;
      check("req_onehot", ($countones({test_rx, test_tx, test_adv}) <= 1), 1);
      if (any_now && !prev_any) begin
        k = test_rx ? 0 : (test_tx ? 1 : 2);
        check("req_expected", (ev_q.size() > 0), 1);
        len_exp = -1;
        if (ev_q.size() > 0) begin
          e = ev_q.pop_front();
          check("req_kind", k, e.kind);
          check("req_bus", bus_sel, e.bus);
          len_exp = e.len;
        end
        if (k == 1 && cur_mode == 2) check("gap_len", cyc - ew_cyc, GAP_CYC + 1);
        hi_len = 1;
      end else if (any_now) begin
        hi_len++;
      end
      if (!any_now && prev_any && len_exp >= 0) check("req_len", hi_len, len_exp);
      if (endwait_all) begin
        ew_cnt++;
        ew_cyc = cyc;
        check("endwait_width", prev_ew, 0);
      end
      if (done && !prev_done) begin
        check("res_expected", (res_q.size() > 0), 1);
        if (res_q.size() > 0) begin
          r = res_q.pop_front();
          check("pass_map", pass_map, r.pm);
          check("fail_map", fail_map, r.fm);
          check("pass_cnt", pass_cnt, r.pc);
          check("timeout_cnt", timeout_cnt, r.tc);
        end
      end
      prev_any  = any_now;
      prev_done = done;
      prev_ew   = endwait_all;
    end
  end

  // Reference model: expected events and results from the plan, then start.
  task automatic launch(input int m, input int n, input bit lp, input bit exp_done);
    int eff, nk, idx, to, ew;
    int kinds[2];
    bit timed;
    plan_t p;
    ev_t e;
    res_t r;
    logic [N_BUS-1:0] fm, pm;
    eff = (n > N_BUS) ? N_BUS : n;
    kinds[0] = (m == 1) ? 1 : (m == 3) ? 2 : 0;
    kinds[1] = 1;
    nk = (m == 2) ? 2 : 1;
    fm = '0; pm = '0; to = 0; ew = 0; idx = 0;
    resp_q = plan_q;
    while (eff > 0 && idx < plan_q.size()) begin
      for (int b = 0; b < eff; b++) begin
        for (int t = 0; t < nk; t++) begin
          if (idx < plan_q.size()) begin
            p = plan_q[idx];
            idx++;
            timed = (p.d == -1) || (p.d >= TIMEOUT_CYC);
            e.kind = kinds[t];
            e.bus  = b;
            e.len  = (p.d == -2) ? -1 : (timed ? TIMEOUT_CYC : p.d + 1);
            if (p.d != -2 && (timed || !p.ok)) fm[b] = 1'b1;
            if (timed) to++;
            if (kinds[t] == 0) ew++;
            ev_q.push_back(e);
          end
        end
        pm[b] = !fm[b];
      end
    end
    if (exp_done) begin
      r.pm = pm; r.fm = fm; r.pc = (eff > 0) ? 1 : 0; r.tc = to;
      res_q.push_back(r);
    end
    exp_ew   = ew;
    ew_cnt   = 0;
    cur_mode = m;
    mode     = 2'(m);
    n_buses  = BUS_W'(n);
    loop_en  = lp;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (!done && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check({name, "_done"}, done, 1);
    check({name, "_busy"}, busy, 0);
    @(negedge clk);
    check({name, "_events_left"}, ev_q.size(), 0);
    check({name, "_results_left"}, res_q.size(), 0);
    check({name, "_endwait_cnt"}, ew_cnt, exp_ew);
  endtask

  task automatic wait_rx_bus1(input string name);
    int t = 0;
    while (!(test_rx && bus_sel == BUS_W'(1)) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check({name, "_reached_bus1"}, (test_rx && bus_sel == BUS_W'(1)), 1);
    repeat (5) @(negedge clk);
  endtask

  initial begin : stimulus
    int t;
    int m, n, nt;
    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'd0; loop_en = 1'b0; n_buses = '0;
    repeat (3) @(negedge clk);
    check("rst_flags", {test_rx, test_tx, test_adv, endwait_all, busy, done}, 0);
    check("rst_bus_sel", bus_sel, 0);
    check("rst_maps", {pass_map, fail_map}, 0);
    check("rst_counters", {pass_cnt, timeout_cnt}, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // RX then TX on three buses, all passing
    plan_q.delete();
    repeat (6) plan_q.push_back('{d: 50, ok: 1'b1});
    launch(2, 3, 1'b0, 1'b1);
    wait_done("rx_tx");
    check("rx_tx_pass_map_const", pass_map, 16'h0007);

    // TX only, bus 2 never answers
    plan_q.delete();
    plan_q.push_back('{d: 10, ok: 1'b1});
    plan_q.push_back('{d: 10, ok: 1'b1});
    plan_q.push_back('{d: -1, ok: 1'b1});
    plan_q.push_back('{d: 10, ok: 1'b1});
    launch(1, 4, 1'b0, 1'b1);
    wait_done("tx_timeout");
    check("tx_timeout_fail_const", fail_map, 16'h0004);
    check("tx_timeout_pass_const", pass_map, 16'h000B);
    check("tx_timeout_cnt_const", timeout_cnt, 1);

    // Advanced only, looping over two buses for three passes, then abort
    plan_q.delete();
    repeat (6) plan_q.push_back('{d: 5, ok: 1'b1});
    plan_q.push_back('{d: -2, ok: 1'b1});
    launch(3, 2, 1'b1, 1'b0);
    t = 0;
    while (pass_cnt != 16'd3 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("loop_pass_cnt", pass_cnt, 3);
    check("loop_busy", busy, 1);
    check("loop_done", done, 0);
    check("loop_adv_req", test_adv, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("loop_abort_req", test_adv, 0);
    check("loop_abort_busy", busy, 0);
    check("loop_abort_done", done, 0);

    // Zero buses: straight to DONE with counters cleared
    plan_q.delete();
    launch(0, 0, 1'b0, 1'b1);
    wait_done("zero_bus");

    // 31 requested buses clamp to 16
    plan_q.delete();
    for (int i = 0; i < N_BUS; i++)
      plan_q.push_back('{d: int'($urandom_range(0, 20)), ok: ($urandom_range(0, 3) != 0)});
    launch(0, 31, 1'b0, 1'b1);
    wait_done("clamp");
    check("clamp_last_bus", bus_sel, N_BUS - 1);

    // TX end on the final timeout cycle counts as an end
    plan_q.delete();
    plan_q.push_back('{d: TIMEOUT_CYC - 1, ok: 1'b1});
    launch(1, 1, 1'b0, 1'b1);
    wait_done("edge_timeout");
    check("edge_timeout_cnt_const", timeout_cnt, 0);

    // Abort during RX of bus 1 keeps maps
    plan_q.delete();
    plan_q.push_back('{d: 3, ok: 1'b0});
    plan_q.push_back('{d: -2, ok: 1'b1});
    launch(0, 2, 1'b0, 1'b0);
    wait_rx_bus1("abort");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_rx", test_rx, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_fail_kept", fail_map, 16'h0001);

    // Reset during RX of bus 1 clears everything
    plan_q.delete();
    plan_q.push_back('{d: 3, ok: 1'b0});
    plan_q.push_back('{d: -2, ok: 1'b1});
    launch(0, 2, 1'b0, 1'b0);
    wait_rx_bus1("reset");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("reset_rx", test_rx, 0);
    check("reset_busy", busy, 0);
    check("reset_maps", {pass_map, fail_map}, 0);
    check("reset_bus_sel", bus_sel, 0);

    // Randomised runs
    for (int run = 0; run < 3; run++) begin
      m  = int'($urandom_range(0, 3));
      n  = int'($urandom_range(1, 5));
      nt = n * ((m == 2) ? 2 : 1);
      plan_q.delete();
      for (int i = 0; i < nt; i++)
        plan_q.push_back('{d: int'($urandom_range(0, 60)), ok: ($urandom_range(0, 3) != 0)});
      launch(m, n, 1'b0, 1'b1);
      wait_done("random");
    end

    check("final_events_left", ev_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
